// File: rtl/psu_pkg.sv
// Shared op encoding and logical-stage split helpers for the pipelined shift unit.
package psu_pkg;

  typedef enum logic [2:0] {
    PSU_ROL = 3'd0,
    PSU_ROR = 3'd1,
    PSU_SLL = 3'd2,
    PSU_SRL = 3'd3,
    PSU_SRA = 3'd4
  } psu_op_e;

  function automatic int psu_sa_w(int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Early physical stages absorb the remainder, one extra logical stage each.
  function automatic int psu_ops_in_stage(int p, int sa_w, int n);
    return sa_w / n + ((p < sa_w % n) ? 1 : 0);
  endfunction

  function automatic int psu_first_op(int p, int sa_w, int n);
    return p * (sa_w / n) + ((p < sa_w % n) ? p : sa_w % n);
  endfunction

endpackage

// File: rtl/psu_stage.sv
// One physical stage: logical shift stages FIRST_K..FIRST_K+NUM_K-1 plus the
// stage register and ready/valid logic. Zero flag present under PSU_ZERO_FLAG_EN.
module psu_stage
  import psu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SA_W       = 5,
  parameter int FIRST_K    = 0,
  parameter int NUM_K      = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid,
  input  logic [2:0]            i_op,
  input  logic [SA_W-1:0]       i_amount,
  input  logic                  i_sign,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_down_adv,
  output logic                  o_adv,
  output logic                  o_valid,
  output logic [2:0]            o_op,
  output logic [SA_W-1:0]       o_amount,
  output logic                  o_sign,
  output logic [DATA_WIDTH-1:0] o_data
`ifdef PSU_ZERO_FLAG_EN
  ,
  output logic                  o_zero
`endif
);

  // Shift amounts >= DATA_WIDTH only occur for DATA_WIDTH=1 and flush to the fill value.
  function automatic logic [DATA_WIDTH-1:0] shift_by(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [2:0] op,
                                                     input logic sign, input int s);
    int rs;
    logic [DATA_WIDTH-1:0] fill;
    rs   = s % DATA_WIDTH;
    fill = sign ? ~({DATA_WIDTH{1'b1}} >> s) : '0;
    case (op)
      PSU_ROL: return (d << rs) | (d >> (DATA_WIDTH - rs));
      PSU_ROR: return (d >> rs) | (d << (DATA_WIDTH - rs));
      PSU_SLL: return d << s;
      PSU_SRL: return d >> s;
      PSU_SRA: return (d >> s) | fill;
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_slice(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [2:0] op,
                                                        input logic [SA_W-1:0] amount,
                                                        input logic sign);
    logic [DATA_WIDTH-1:0] r;
    logic [SA_W-1:0]       a;
    r = d;
    for (int k = FIRST_K; k < FIRST_K + NUM_K; k++) begin
      a = amount >> k;
      if (a[0]) r = shift_by(r, op, sign, 1 << k);
    end
    return r;
  endfunction

  logic                  r_valid;
  logic [2:0]            r_op;
  logic [SA_W-1:0]       r_amount;
  logic                  r_sign;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_next;

  assign w_next = apply_slice(i_data, i_op, i_amount, i_sign);
  assign o_adv  = !r_valid || i_down_adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_op     <= '0;
      r_amount <= '0;
      r_sign   <= 1'b0;
      r_data   <= '0;
    end else if (o_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_op     <= i_op;
        r_amount <= i_amount;
        r_sign   <= i_sign;
        r_data   <= w_next;
      end
    end
  end

`ifdef PSU_ZERO_FLAG_EN
  logic r_zero;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_zero <= 1'b0;
    else if (o_adv && i_valid)   r_zero <= (w_next == '0);
  end
  assign o_zero = r_zero;
`endif

  assign o_valid  = r_valid;
  assign o_op     = r_op;
  assign o_amount = r_amount;
  assign o_sign   = r_sign;
  assign o_data   = r_data;

endmodule

// File: rtl/pipelined_shift_unit.sv
// Multi-mode pipelined barrel shifter with valid/ready flow control.
// Define PSU_ZERO_FLAG_EN to add the registered out_zero result flag.
module pipelined_shift_unit
  import psu_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_STAGES = 2,
  localparam int SA_W       = psu_sa_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [SA_W-1:0]       in_amount,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef PSU_ZERO_FLAG_EN
  ,
  output logic                  out_zero
`endif
);

  localparam int EFF_NUM_STAGES = (NUM_STAGES < 1) ? 1 : NUM_STAGES;

  logic                  w_valid  [0:EFF_NUM_STAGES];
  logic [2:0]            w_op     [0:EFF_NUM_STAGES];
  logic [SA_W-1:0]       w_amount [0:EFF_NUM_STAGES];
  logic                  w_sign   [0:EFF_NUM_STAGES];
  logic [DATA_WIDTH-1:0] w_data   [0:EFF_NUM_STAGES];

  assign w_valid[0]  = in_valid;
  assign w_op[0]     = in_op;
  assign w_amount[0] = in_amount;
  assign w_sign[0]   = in_data[DATA_WIDTH-1];
  assign w_data[0]   = in_data;

  // Advance signals live in per-stage scopes so the ready chain is not one self-dependent array.
  for (genvar p = 0; p < EFF_NUM_STAGES; p++) begin : g_stage
    logic w_adv;
    logic w_down_adv;
`ifdef PSU_ZERO_FLAG_EN
    logic w_zero;
`endif

    if (p == EFF_NUM_STAGES - 1) begin : g_tail
      assign w_down_adv = out_ready;
    end else begin : g_link
      assign w_down_adv = g_stage[p+1].w_adv;
    end

    psu_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .SA_W       (SA_W),
      .FIRST_K    (psu_first_op(p, SA_W, EFF_NUM_STAGES)),
      .NUM_K      (psu_ops_in_stage(p, SA_W, EFF_NUM_STAGES))
    ) u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_valid    (w_valid[p]),
      .i_op       (w_op[p]),
      .i_amount   (w_amount[p]),
      .i_sign     (w_sign[p]),
      .i_data     (w_data[p]),
      .i_down_adv (w_down_adv),
      .o_adv      (w_adv),
      .o_valid    (w_valid[p+1]),
      .o_op       (w_op[p+1]),
      .o_amount   (w_amount[p+1]),
      .o_sign     (w_sign[p+1]),
      .o_data     (w_data[p+1])
`ifdef PSU_ZERO_FLAG_EN
      ,
      .o_zero     (w_zero)
`endif
    );
  end

  assign in_ready  = g_stage[0].w_adv;
  assign out_valid = w_valid[EFF_NUM_STAGES];
  assign out_data  = w_data[EFF_NUM_STAGES];
`ifdef PSU_ZERO_FLAG_EN
  assign out_zero  = g_stage[EFF_NUM_STAGES-1].w_zero;
`endif

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench for pipelined_shift_unit across three configurations
// (8b/2 stages, 5b/3 stages, 1b/0 stages); honours PSU_ZERO_FLAG_EN.
module tb_pipelined_shift_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] in_op, in_amount;
  logic [7:0] in_data, out_data;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0] b_in_op, b_in_amount;
  logic [4:0] b_in_data, b_out_data;

  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [2:0] c_in_op;
  logic       c_in_amount, c_in_data, c_out_data;

`ifdef PSU_ZERO_FLAG_EN
  logic out_zero, b_out_zero, c_out_zero;
`endif

  pipelined_shift_unit #(.DATA_WIDTH(8), .NUM_STAGES(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_amount(in_amount), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PSU_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  pipelined_shift_unit #(.DATA_WIDTH(5), .NUM_STAGES(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_op(b_in_op), .in_amount(b_in_amount), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef PSU_ZERO_FLAG_EN
    , .out_zero(b_out_zero)
`endif
  );

  pipelined_shift_unit #(.DATA_WIDTH(1), .NUM_STAGES(0)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_op(c_in_op), .in_amount(c_in_amount), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data)
`ifdef PSU_ZERO_FLAG_EN
    , .out_zero(c_out_zero)
`endif
  );

  // Reference: apply the whole amount as repeated single-bit moves on a w-bit word.
  function automatic logic [31:0] ref_shift(input int w, input logic [2:0] op, input int amt,
                                            input logic [31:0] d);
    logic [63:0] x, mask, msb;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    for (int j = 0; j < amt; j++) begin
      msb = (x >> (w - 1)) & 64'd1;
      case (op)
        3'd0:    x = ((x << 1) | msb) & mask;
        3'd1:    x = ((x >> 1) | ((x & 64'd1) << (w - 1))) & mask;
        3'd2:    x = (x << 1) & mask;
        3'd3:    x = x >> 1;
        3'd4:    x = (x >> 1) | (msb << (w - 1));
        default: x = x;
      endcase
    end
    return x[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_a(input string tag, input logic [2:0] op, input logic [2:0] amt,
                          input logic [7:0] d, input logic [7:0] exp);
    int lat;
    in_valid = 1'b1; in_op = op; in_amount = amt; in_data = d;
    lat = 0;
    do begin
      tick();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 10);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
`ifdef PSU_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(out_zero), 32'(exp == 8'h00));
`endif
    tick();
    chk({tag, "_once"}, 32'(out_valid), 32'd0);
  endtask

  task automatic single_b(input string tag, input logic [2:0] op, input logic [2:0] amt,
                          input logic [4:0] d);
    int lat;
    logic [31:0] e;
    e = ref_shift(5, op, int'(amt), 32'(d));
    b_in_valid = 1'b1; b_in_op = op; b_in_amount = amt; b_in_data = d;
    lat = 0;
    do begin
      tick();
      lat++;
      b_in_valid = 1'b0;
    end while (!b_out_valid && lat < 10);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, 32'(b_out_data), e);
    tick();
  endtask

  task automatic single_c(input string tag, input logic [2:0] op, input logic amt,
                          input logic d, input logic exp);
    int lat;
    c_in_valid = 1'b1; c_in_op = op; c_in_amount = amt; c_in_data = d;
    #1;
    chk({tag, "_ready"}, 32'(c_in_ready), 32'd1);
    lat = 0;
    do begin
      tick();
      lat++;
      c_in_valid = 1'b0;
    end while (!c_out_valid && lat < 10);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_data"}, 32'(c_out_data), 32'(exp));
`ifdef PSU_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(c_out_zero), 32'(exp == 1'b0));
`endif
    tick();
    chk({tag, "_once"}, 32'(c_out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] qa[$], qb[$], exp_q[$], got_q[$];
  logic [7:0]  send_q[$];
  int          cyc_q[$];
  int          got, gaps, rdy_drop, sent, seen;
  logic        acc, pend, hold;
  logic [31:0] e, prev;

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_amount = '0; in_data = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_op = '0; b_in_amount = '0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_op = '0; c_in_amount = 1'b0; c_in_data = 1'b0; c_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    chk("rst_c_out_valid", 32'(c_out_valid), 32'd0);
`ifdef PSU_ZERO_FLAG_EN
    chk("rst_out_zero", 32'(out_zero), 32'd0);
`endif
    #2 reset_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Directed op sweep plus zero-flag vectors
    single_a("rol", 3'd0, 3'd1, 8'h81, 8'h03);
    single_a("ror", 3'd1, 3'd1, 8'h01, 8'h80);
    single_a("sll", 3'd2, 3'd4, 8'hFF, 8'hF0);
    single_a("srl", 3'd3, 3'd7, 8'h80, 8'h01);
    single_a("sra", 3'd4, 3'd3, 8'h80, 8'hF0);
    single_a("rsv", 3'd6, 3'd2, 8'h5A, 8'h5A);
    single_a("zsll", 3'd2, 3'd1, 8'h80, 8'h00);
    single_a("zrol", 3'd0, 3'd1, 8'h80, 8'h01);

    // Back-to-back random streaming with out_ready held high
    got = 0; gaps = 0; rdy_drop = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_op = 3'($urandom_range(7, 0));
      in_amount = 3'($urandom_range(7, 0));
      in_data = 8'($urandom);
      #1;
      if (!in_ready) rdy_drop++;
      qa.push_back(ref_shift(8, in_op, int'(in_amount), 32'(in_data)));
      tick();
      if (out_valid) begin
        if (qa.size() == 0) chk("stream_extra", 32'(out_valid), 32'd0);
        else begin
          e = qa.pop_front();
          chk("stream_data", 32'(out_data), e);
          got++;
        end
      end else if (got > 0) gaps++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) begin
        if (qa.size() == 0) chk("stream_extra", 32'(out_valid), 32'd0);
        else begin
          e = qa.pop_front();
          chk("stream_data", 32'(out_data), e);
          got++;
        end
      end else if (got > 0 && got < 100) gaps++;
    end
    chk("stream_count", 32'(got), 32'd100);
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_ready_drops", 32'(rdy_drop), 32'd0);

    // Backpressure: A,B,C with output stalled for 5 cycles, then released
    send_q = '{8'hA5, 8'h3C, 8'hF0};
    exp_q.delete();
    foreach (send_q[k]) exp_q.push_back(ref_shift(8, 3'd4, 2, 32'(send_q[k])));
    out_ready = 1'b0; in_op = 3'd4; in_amount = 3'd2;
    for (int c = 0; c < 5; c++) begin
      in_valid = (send_q.size() > 0);
      if (send_q.size() > 0) in_data = send_q[0];
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc) void'(send_q.pop_front());
      if (c >= 1) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_data", 32'(out_data), exp_q[0]);
`ifdef PSU_ZERO_FLAG_EN
        chk("bp_hold_zero", 32'(out_zero), 32'(exp_q[0] == 32'd0));
`endif
      end
    end
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_accepted", 32'(3 - send_q.size()), 32'd2);
    out_ready = 1'b1;
    got_q.delete(); cyc_q.delete();
    for (int c = 0; c < 8; c++) begin
      in_valid = (send_q.size() > 0);
      if (send_q.size() > 0) in_data = send_q[0];
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        got_q.push_back(32'(out_data));
        cyc_q.push_back(c);
      end
      tick();
      if (acc) void'(send_q.pop_front());
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(got_q.size()), 32'd3);
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      chk("bp_order", got_q[k], exp_q[k]);
      if (k > 0) chk("bp_consecutive", 32'(cyc_q[k] - cyc_q[k-1]), 32'd1);
    end

    // Config: 5-bit, 3 stages -- latency then random stream with random backpressure
    single_b("b_first", 3'd0, 3'd7, 5'b10011);
    single_b("b_sra", 3'd4, 3'd6, 5'b10110);
    got = 0; sent = 0; pend = 1'b0; hold = 1'b0; prev = '0;
    for (int c = 0; c < 600 && got < 40; c++) begin
      b_out_ready = 1'($urandom_range(1, 0));
      if (!pend && sent < 40) begin
        b_in_op = 3'($urandom_range(7, 0));
        b_in_amount = 3'($urandom_range(7, 0));
        b_in_data = 5'($urandom);
        pend = 1'b1;
      end
      b_in_valid = pend;
      #1;
      if (hold) begin
        chk("b_hold_valid", 32'(b_out_valid), 32'd1);
        chk("b_hold_data", 32'(b_out_data), prev);
      end
      acc = b_in_valid && b_in_ready;
      if (acc) qb.push_back(ref_shift(5, b_in_op, int'(b_in_amount), 32'(b_in_data)));
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_extra", 32'(b_out_valid), 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_data", 32'(b_out_data), e);
`ifdef PSU_ZERO_FLAG_EN
          chk("b_zero", 32'(b_out_zero), 32'(e == 32'd0));
`endif
          got++;
        end
      end
      hold = b_out_valid && !b_out_ready;
      prev = 32'(b_out_data);
      tick();
      if (acc) begin
        pend = 1'b0;
        sent++;
      end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    chk("b_count", 32'(got), 32'd40);

    // Config: 1-bit, NUM_STAGES=0 behaves as one stage
    single_c("c_sll_1by1", 3'd2, 1'b1, 1'b1, 1'b0);
    for (int o = 0; o < 8; o++)
      single_c("c_op", 3'(o), 1'b1, 1'b1, ref_shift(1, 3'(o), 1, 32'd1) != 32'd0);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b1; in_op = 3'd0; in_amount = 3'd1;
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_data = 8'h66;
    tick();
    in_valid = 1'b0;
    chk("mid_valid_before", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    #2 reset_n = 1'b1;
    #1 chk("mid_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_no_stale", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
